// File: rtl/projectile_pool.sv
// Projectile slot pool for one shooter class: allocates slots on fire requests,
// advances live projectiles every frame tick and retires them on hit or leaving the field.
module projectile_pool #(
   parameter int SLOTS    = 8,
   parameter int X_W      = 10,
   parameter int Y_W      = 9,
   parameter int STEP     = 4,
   parameter int DIR      = 0,
   parameter int Y_LIMIT  = 479,
   parameter int COOLDOWN = 8
) (
   input  logic                         i_Clk,
   input  logic                         i_Rst,
   input  logic                         i_Tick,
   input  logic                         i_Clear,
   input  logic                         i_FireReq,
   input  logic [X_W-1:0]               i_FireX,
   input  logic [Y_W-1:0]               i_FireY,
   output logic                         o_FireAck,
   input  logic [SLOTS-1:0]             i_Hit,
   output logic [SLOTS-1:0]             o_Active,
   output logic [SLOTS*X_W-1:0]         o_PosX,
   output logic [SLOTS*Y_W-1:0]         o_PosY,
   output logic [SLOTS-1:0]             o_OobMask,
   output logic [$clog2(SLOTS+1)-1:0]   o_Count,
   output logic                         o_Full
);

   localparam int CNT_W = $clog2(SLOTS + 1);
   // One spare code keeps the counter at least one bit wide when COOLDOWN is 0.
   localparam int CD_W  = $clog2(COOLDOWN + 2);
   localparam int DN_MAX = Y_LIMIT - STEP;
   localparam bit DN_ALL = (DN_MAX < 0);
   localparam logic [Y_W:0]      STEP_E   = (Y_W+1)'(STEP);
   localparam logic [Y_W:0]      LIMIT_E  = (Y_W+1)'(Y_LIMIT);
   localparam logic [Y_W:0]      DN_MAX_E = DN_ALL ? {(Y_W+1){1'b0}} : (Y_W+1)'(DN_MAX);
   localparam logic [CD_W-1:0]   CD_LOAD  = CD_W'(COOLDOWN);

   logic [SLOTS-1:0]       active_q, active_d;
   logic [SLOTS*X_W-1:0]   posx_q, posx_d;
   logic [SLOTS*Y_W-1:0]   posy_q, posy_d;
   logic [CD_W-1:0]        cool_q, cool_d;
   logic                   ack_q, ack_d;
   logic [SLOTS-1:0]       oob_q, oob_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   full_q, full_d;

   logic [SLOTS-1:0]       hit_s, oob_s, alloc_s;
   logic [SLOTS*Y_W-1:0]   posy_mv_s;
   logic [Y_W:0]           y_ext_s, y_new_s;
   logic                   move_s, retire_s, found_s, accept_s;
   logic [Y_W-1:0]         spawn_y_s;

   // Per-slot movement, bound retire and lowest-free-slot search, all on start-of-cycle state.
   always_comb begin
      hit_s     = i_Hit & active_q;
      oob_s     = {SLOTS{1'b0}};
      alloc_s   = {SLOTS{1'b0}};
      posy_mv_s = posy_q;
      y_ext_s   = {(Y_W+1){1'b0}};
      y_new_s   = {(Y_W+1){1'b0}};
      move_s    = 1'b0;
      retire_s  = 1'b0;
      found_s   = 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
         move_s   = i_Tick & active_q[k] & ~hit_s[k];
         y_ext_s  = {1'b0, posy_q[k*Y_W +: Y_W]};
         retire_s = (DIR == 0) ? (y_ext_s < STEP_E) : (DN_ALL || (y_ext_s > DN_MAX_E));
         y_new_s  = (DIR == 0) ? (y_ext_s - STEP_E) : (y_ext_s + STEP_E);
         oob_s[k] = move_s & retire_s;
         posy_mv_s[k*Y_W +: Y_W] = (move_s & ~retire_s) ? y_new_s[Y_W-1:0]
                                                        : posy_q[k*Y_W +: Y_W];
         alloc_s[k] = ~active_q[k] & ~found_s;
         found_s    = found_s | ~active_q[k];
      end
   end

   // Next-state: clear beats hit, hit beats movement, movement beats fire.
   always_comb begin
      accept_s  = i_FireReq & (cool_q == {CD_W{1'b0}}) & ~i_Clear & ~(&active_q);
      spawn_y_s = ({1'b0, i_FireY} > LIMIT_E) ? LIMIT_E[Y_W-1:0] : i_FireY;
      active_d  = i_Clear ? {SLOTS{1'b0}}
                          : ((active_q & ~hit_s & ~oob_s) | (accept_s ? alloc_s : {SLOTS{1'b0}}));
      oob_d     = i_Clear ? {SLOTS{1'b0}} : oob_s;
      ack_d     = accept_s;
      posx_d    = posx_q;
      posy_d    = i_Clear ? posy_q : posy_mv_s;
      for (int k = 0; k < SLOTS; k++) begin
         posx_d[k*X_W +: X_W] = (accept_s & alloc_s[k]) ? i_FireX : posx_q[k*X_W +: X_W];
         posy_d[k*Y_W +: Y_W] = (accept_s & alloc_s[k]) ? spawn_y_s : posy_d[k*Y_W +: Y_W];
      end
      if (i_Clear) begin
         cool_d = {CD_W{1'b0}};
      end else if (accept_s) begin
         cool_d = CD_LOAD;
      end else if (i_Tick && (cool_q != {CD_W{1'b0}})) begin
         cool_d = cool_q - CD_W'(1'b1);
      end else begin
         cool_d = cool_q;
      end
   end

   // Live-slot count and full flag follow the next active mask so they register together.
   always_comb begin
      count_d = {CNT_W{1'b0}};
      for (int k = 0; k < SLOTS; k++) begin
         count_d = count_d + CNT_W'(active_d[k]);
      end
      full_d = (count_d == CNT_W'(SLOTS));
   end

   // State registers.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         active_q <= {SLOTS{1'b0}};
         posx_q   <= {(SLOTS*X_W){1'b0}};
         posy_q   <= {(SLOTS*Y_W){1'b0}};
         cool_q   <= {CD_W{1'b0}};
         ack_q    <= 1'b0;
         oob_q    <= {SLOTS{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         full_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         posx_q   <= posx_d;
         posy_q   <= posy_d;
         cool_q   <= cool_d;
         ack_q    <= ack_d;
         oob_q    <= oob_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   assign o_Active  = active_q;
   assign o_PosX    = posx_q;
   assign o_PosY    = posy_q;
   assign o_FireAck = ack_q;
   assign o_OobMask = oob_q;
   assign o_Count   = count_q;
   assign o_Full    = full_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Scoreboard bench: stimulus queues expected acks / out-of-bound masks, a forked
// monitor pops them whenever the DUT pulses o_FireAck or o_OobMask.
module tb_projectile_pool;

   typedef struct packed {
      logic [1:0] slot;
      logic [9:0] x;
      logic [8:0] y;
   } ack_t;

   logic clk;
   logic rst;

   // Instance A: up, cooldown 2.  Instance B: down, no cooldown.
   logic tick_a, clr_a, req_a, ack_a, full_a;
   logic [9:0] fx_a;
   logic [8:0] fy_a;
   logic [3:0] hit_a, act_a, oob_a;
   logic [39:0] px_a;
   logic [35:0] py_a;
   logic [2:0] cnt_a;

   logic tick_b, clr_b, req_b, ack_b, full_b;
   logic [9:0] fx_b;
   logic [8:0] fy_b;
   logic [3:0] hit_b, act_b, oob_b;
   logic [39:0] px_b;
   logic [35:0] py_b;
   logic [2:0] cnt_b;

   int n_vec;
   int n_err;
   ack_t qa[$];
   ack_t qb[$];
   logic [3:0] qoa[$];
   logic [3:0] qob[$];

   projectile_pool #(.SLOTS(4), .X_W(10), .Y_W(9), .STEP(4), .DIR(0), .Y_LIMIT(479), .COOLDOWN(2)) u_a (
      .i_Clk(clk), .i_Rst(rst), .i_Tick(tick_a), .i_Clear(clr_a), .i_FireReq(req_a),
      .i_FireX(fx_a), .i_FireY(fy_a), .o_FireAck(ack_a), .i_Hit(hit_a), .o_Active(act_a),
      .o_PosX(px_a), .o_PosY(py_a), .o_OobMask(oob_a), .o_Count(cnt_a), .o_Full(full_a));

   projectile_pool #(.SLOTS(4), .X_W(10), .Y_W(9), .STEP(4), .DIR(1), .Y_LIMIT(479), .COOLDOWN(0)) u_b (
      .i_Clk(clk), .i_Rst(rst), .i_Tick(tick_b), .i_Clear(clr_b), .i_FireReq(req_b),
      .i_FireX(fx_b), .i_FireY(fy_b), .o_FireAck(ack_b), .i_Hit(hit_b), .o_Active(act_b),
      .o_PosX(px_b), .o_PosY(py_b), .o_OobMask(oob_b), .o_Count(cnt_b), .o_Full(full_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // One clock; single-cycle inputs drop back to 0 afterwards.
   task automatic step();
      @(negedge clk);
      tick_a = 1'b0; clr_a = 1'b0; hit_a = 4'd0;
      tick_b = 1'b0; clr_b = 1'b0; hit_b = 4'd0;
   endtask

   initial begin
      ack_t ea;
      ack_t eb;
      logic [3:0] ma;
      logic [3:0] mb;
      n_vec = 0; n_err = 0;
      rst = 1'b0;
      tick_a = 1'b0; clr_a = 1'b0; req_a = 1'b0; fx_a = 10'd0; fy_a = 9'd0; hit_a = 4'd0;
      tick_b = 1'b0; clr_b = 1'b0; req_b = 1'b0; fx_b = 10'd0; fy_b = 9'd0; hit_b = 4'd0;

      fork
         forever begin
            @(negedge clk);
            if (ack_a) begin
               if (qa.size() == 0) chk("A unexpected ack", {63'd0, ack_a}, 64'd0);
               else begin
                  ea = qa.pop_front();
                  chk("A ack slot live", {63'd0, act_a[ea.slot]}, 64'd1);
                  chk("A spawn x", {54'd0, px_a[ea.slot*10 +: 10]}, {54'd0, ea.x});
                  chk("A spawn y", {55'd0, py_a[ea.slot*9 +: 9]}, {55'd0, ea.y});
               end
            end
            if (ack_b) begin
               if (qb.size() == 0) chk("B unexpected ack", {63'd0, ack_b}, 64'd0);
               else begin
                  eb = qb.pop_front();
                  chk("B ack slot live", {63'd0, act_b[eb.slot]}, 64'd1);
                  chk("B spawn x", {54'd0, px_b[eb.slot*10 +: 10]}, {54'd0, eb.x});
                  chk("B spawn y", {55'd0, py_b[eb.slot*9 +: 9]}, {55'd0, eb.y});
               end
            end
            if (oob_a != 4'd0) begin
               if (qoa.size() == 0) chk("A unexpected oob", {60'd0, oob_a}, 64'd0);
               else begin ma = qoa.pop_front(); chk("A oob mask", {60'd0, oob_a}, {60'd0, ma}); end
            end
            if (oob_b != 4'd0) begin
               if (qob.size() == 0) chk("B unexpected oob", {60'd0, oob_b}, 64'd0);
               else begin mb = qob.pop_front(); chk("B oob mask", {60'd0, oob_b}, {60'd0, mb}); end
            end
         end
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst A active", {60'd0, act_a}, 64'd0);
      chk("rst A count", {61'd0, cnt_a}, 64'd0);
      chk("rst A full", {63'd0, full_a}, 64'd0);
      chk("rst A ack", {63'd0, ack_a}, 64'd0);
      chk("rst A posx", {24'd0, px_a}, 64'd0);
      chk("rst A posy", {28'd0, py_a}, 64'd0);
      chk("rst B active", {60'd0, act_b}, 64'd0);
      chk("rst B oob", {60'd0, oob_b}, 64'd0);
      rst = 1'b1;
      step();

      // Fire, cooldown 2, auto-fire on held request
      req_a = 1'b1; fx_a = 10'd100; fy_a = 9'd400;
      qa.push_back('{2'd0, 10'd100, 9'd400});
      step();
      chk("T1 active", {60'd0, act_a}, 64'd1);
      step(); step();
      tick_a = 1'b1; step();
      tick_a = 1'b1; step();
      qa.push_back('{2'd1, 10'd100, 9'd400});
      step();
      req_a = 1'b0;
      chk("T1 active2", {60'd0, act_a}, 64'd3);
      chk("T1 slot0 y", {55'd0, py_a[8:0]}, 64'd392);
      chk("T1 count", {61'd0, cnt_a}, 64'd2);

      // Clear beats fire; positions survive; cooldown zeroed
      clr_a = 1'b1; req_a = 1'b1; fx_a = 10'd5; fy_a = 9'd6;
      step();
      chk("clr active", {60'd0, act_a}, 64'd0);
      chk("clr count", {61'd0, cnt_a}, 64'd0);
      chk("clr keeps x0", {54'd0, px_a[9:0]}, 64'd100);
      chk("clr keeps y1", {55'd0, py_a[17:9]}, 64'd400);
      qa.push_back('{2'd0, 10'd5, 9'd6});
      step();
      req_a = 1'b0;
      chk("post-clr fire", {60'd0, act_a}, 64'd1);

      // Movement and out-of-bound retire (up)
      tick_a = 1'b1; step();
      chk("T2 y after tick", {55'd0, py_a[8:0]}, 64'd2);
      chk("T2 count", {61'd0, cnt_a}, 64'd1);
      tick_a = 1'b1; qoa.push_back(4'b0001); step();
      chk("T2 retired", {60'd0, act_a}, 64'd0);
      chk("T2 count0", {61'd0, cnt_a}, 64'd0);
      step();
      chk("T2 oob one cycle", {60'd0, oob_a}, 64'd0);

      // Full pool on B
      req_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         fx_b = 10'(10 + k); fy_b = 9'(100 + 10 * k);
         qb.push_back('{2'(k), 10'(10 + k), 9'(100 + 10 * k)});
         step();
      end
      chk("T3 full", {63'd0, full_b}, 64'd1);
      chk("T3 count", {61'd0, cnt_b}, 64'd4);
      step();
      hit_b = 4'b0100; step();
      chk("T3 hit active", {60'd0, act_b}, 64'd11);
      chk("T3 hit count", {61'd0, cnt_b}, 64'd3);
      chk("T3 not full", {63'd0, full_b}, 64'd0);
      fx_b = 10'd77; fy_b = 9'd200;
      qb.push_back('{2'd2, 10'd77, 9'd200});
      step();
      req_b = 1'b0;
      chk("T3 refill", {60'd0, act_b}, 64'd15);

      // Simultaneous tick + hit + fire
      hit_b = 4'b1000; step();
      chk("T4 pre", {60'd0, act_b}, 64'd7);
      tick_b = 1'b1; hit_b = 4'b0010; req_b = 1'b1; fx_b = 10'd33; fy_b = 9'd300;
      qb.push_back('{2'd3, 10'd33, 9'd300});
      step();
      req_b = 1'b0;
      chk("T4 active", {60'd0, act_b}, 64'd13);
      chk("T4 y0 moved", {55'd0, py_b[8:0]}, 64'd104);
      chk("T4 y2 moved", {55'd0, py_b[26:18]}, 64'd204);
      chk("T4 y3 unmoved", {55'd0, py_b[35:27]}, 64'd300);
      chk("T4 count", {61'd0, cnt_b}, 64'd3);

      // Down mode with clamp
      clr_b = 1'b1; step();
      chk("T5 cleared", {60'd0, act_b}, 64'd0);
      req_b = 1'b1; fx_b = 10'd1; fy_b = 9'd500;
      qb.push_back('{2'd0, 10'd1, 9'd479});
      step();
      req_b = 1'b0;
      tick_b = 1'b1; qob.push_back(4'b0001); step();
      chk("T5 clamp retire", {60'd0, act_b}, 64'd0);
      req_b = 1'b1; fy_b = 9'd475;
      qb.push_back('{2'd0, 10'd1, 9'd475});
      step();
      req_b = 1'b0;
      tick_b = 1'b1; hit_b = 4'b0010; step();
      chk("T5 y 479", {55'd0, py_b[8:0]}, 64'd479);
      chk("T5 idle hit ignored", {60'd0, act_b}, 64'd1);
      tick_b = 1'b1; qob.push_back(4'b0001); step();
      chk("T5 retire", {60'd0, act_b}, 64'd0);
      step(); #1;
      chk("A acks pending", 64'(qa.size()), 64'd0);
      chk("B acks pending", 64'(qb.size()), 64'd0);
      chk("A oob pending", 64'(qoa.size()), 64'd0);
      chk("B oob pending", 64'(qob.size()), 64'd0);

      // Asynchronous reset mid-cycle while an ack pulse is showing
      req_a = 1'b1; fx_a = 10'd200; fy_a = 9'd300;
      qa.push_back('{2'd0, 10'd200, 9'd300});
      step();
      req_a = 1'b0; tick_a = 1'b1;
      #3 rst = 1'b0;
      #1;
      chk("async ack", {63'd0, ack_a}, 64'd0);
      chk("async active", {60'd0, act_a}, 64'd0);
      chk("async count", {61'd0, cnt_a}, 64'd0);
      chk("async posx", {24'd0, px_a}, 64'd0);
      chk("async posy", {28'd0, py_a}, 64'd0);
      @(negedge clk);
      tick_a = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/projectile_pool.md
Name: projectile_pool

Overview:
Parametrised projectile engine that owns a pool of bullet slots for one shooter class, either the player or the enemies. It accepts fire requests, allocates free slots, and advances every live projectile once per frame tick. Projectiles retire when they leave the play field or when the collision logic reports a hit. It replaces the fixed-size, per-entity bullet arrays with one instance per shooter class, and the game core and renderer read the slot positions directly.

Parameters:
- SLOTS, 8, number of projectile slots (1..32).
- X_W, 10, X coordinate width.
- Y_W, 9, Y coordinate width.
- STEP, 4, pixels moved per tick (1..2^Y_W-1).
- DIR, 0, direction: 0 = up (Y decreasing), 1 = down (Y increasing).
- Y_LIMIT, 479, largest legal Y value.
- COOLDOWN, 8, ticks between accepted shots (0 = no cooldown).

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset, asynchronous, active-low.
- i_Tick  in  1  one-cycle frame tick; triggers movement and cooldown decrement.
- i_Clear  in  1  synchronous clear of the whole pool.
- i_FireReq  in  1  fire request, level-sensitive.
- i_FireX  in  X_W  spawn X.
- i_FireY  in  Y_W  spawn Y.
- o_FireAck  out  1  pulse: request accepted.
- i_Hit  in  SLOTS  per-slot collision retire.
- o_Active  out  SLOTS  slot-live mask.
- o_PosX  out  SLOTS*X_W  packed X positions; slot k is bits [k*X_W +: X_W].
- o_PosY  out  SLOTS*Y_W  packed Y positions, packed the same way.
- o_OobMask  out  SLOTS  pulse: slots retired out-of-bound this tick.
- o_Count  out  $clog2(SLOTS+1)  number of live slots.
- o_Full  out  1  all slots live.

Behaviour:
- **Reset.** All outputs are 0: o_Active, positions, o_FireAck, o_OobMask, o_Count, o_Full. The cooldown counter is 0.
- **Registers and latency.** All state is registered on the rising edge of i_Clk. Every output is driven from registers, so each output reflects the state one cycle after the triggering input.
- **Priority per cycle.** From highest to lowest: i_Clear, then hit retire, then tick movement, then fire.
- **Clear.**
  - All slots become inactive and the cooldown is 0.
  - o_FireAck and o_OobMask are 0 next cycle.
  - Position registers keep their values.
- **Accept condition.** A fire request is accepted when all of the following hold: i_FireReq=1, cooldown==0, i_Clear=0, and at least one slot was inactive at the start of the cycle.
- **Slot allocation.**
  - The accepted request takes the lowest-index inactive slot.
  - A slot freed by a hit or out-of-bound retire in the same cycle is not reusable until the next cycle.
- **On accept.**
  - The slot becomes active with X=i_FireX.
  - Y=min(i_FireY, Y_LIMIT).
  - Cooldown loads COOLDOWN.
  - o_FireAck=1 for exactly the next cycle.
- **Held request.** A request held high fires again automatically once the cooldown expires (auto-fire). The shooter edge-detects if single shots are wanted.
- **Rejected request.** No state change and o_FireAck=0. A request is not queued.
- **Cooldown.**
  - Decrements by 1 on each i_Tick and saturates at 0.
  - A tick and an accept in the same cycle leave cooldown=COOLDOWN, so the load wins.
- **Movement on i_Tick.** Applies to each slot that is active and not hit this cycle.
  - DIR=0: if Y < STEP, the slot retires; otherwise Y = Y - STEP.
  - DIR=1: if Y > Y_LIMIT - STEP, the slot retires; otherwise Y = Y + STEP.
  - Compare in Y_W+1 bits so there is no wrap-around.
  - X is unchanged.
  - A slot spawned in the same cycle as a tick is not moved by that tick.
- **Out-of-bound mask.**
  - o_OobMask shows the bound-retired slots for one cycle after the tick and is 0 otherwise.
  - Hit-retired slots never appear in o_OobMask.
- **Hits.**
  - i_Hit[k] with slot k active retires slot k next cycle, whether or not a tick is present.
  - i_Hit[k] on an inactive slot is ignored.
  - Several hits in one cycle are all honoured.
- **Count and full.** o_Count is the popcount of o_Active. o_Full = (o_Count == SLOTS). Both are registered together with o_Active.
- **Reset mid-operation.** Reset asserted mid-operation aborts everything immediately; no pulse survives reset.

Test Plan:
1. **Fire, cooldown, auto-fire.** SLOTS=4, DIR=0, STEP=4, COOLDOWN=2; hold FireReq with X=100, Y=400.
   - Slot0 goes active at (100,400) and o_FireAck pulses once.
   - There is no second ack until 2 ticks have passed.
   - The next ack fills slot1.
2. **Movement and out-of-bound retire.** Slot0 at Y=6.
   - Tick 1: Y becomes 2.
   - Tick 2: Y<4, so slot0 retires and o_OobMask=4'b0001 for one cycle.
   - o_Count decrements.
3. **Full pool.** COOLDOWN=0; fire 4 times.
   - o_Full=1 and o_Count=4.
   - A 5th request gets no ack.
   - Hit on slot2: the next fire reuses slot2 one cycle later, not in the same cycle.
4. **Simultaneous events.** In one cycle, assert i_Tick, i_Hit=4'b0010, and FireReq with slot3 free.
   - Slot1 retires and does not appear in o_OobMask.
   - The other live slots move.
   - Slot3 spawns at the unmoved request position.
5. **Down mode and clamp.** DIR=1, Y_LIMIT=479, STEP=4.
   - Spawn at Y=500: slot is stored at Y=479.
   - Next tick: slot retires and its o_OobMask bit is set.
   - Spawn at Y=475: first tick moves it to 479; second tick retires it.
6. **Clear versus reset.**
   - i_Clear together with FireReq: o_Active=0, no ack, cooldown=0.
   - Async reset mid-tick: all outputs read 0 immediately.
